test_disp_scanner: RTL and testbench
====================================

# test_disp_scanner

- Time-multiplexes up to NUM_DIGITS 3-bit test-status codes onto one shared status-to-segment decoder and one common 7-segment bus.
- Sits between the test logic that produces status codes and the decoder.
- Holds a code table written through a valid/ready port.
- Scans the digits with a blanking gap between them, and drives the decoder input, a one-hot digit select and a blank strobe.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned; 2..8.
- HOLD_CYCLES, 1000, cycles each digit is lit; ≥1.
- BLANK_CYCLES, 16, cycles all digits are dark between digits; ≥1.

Ports (IW = $clog2(NUM_DIGITS)):
- clk  in  1  sole clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; level-sensitive.
- upd_valid  in  1  table write request.
- upd_idx  in  IW  digit to write.
- upd_code  in  3  status code to store.
- upd_ready  out  1  write accepted this cycle when upd_valid && upd_ready.
- code_out  out  3  registered code to the decoder.
- digit_sel  out  NUM_DIGITS  one-hot, active-high digit enable.
- blank  out  1  high while no digit is lit.
- scan_wrap  out  1  one-cycle pulse at the end of each full frame.

## Operation
- Code table: NUM_DIGITS × 3-bit registers; reset value RESET_CODE = 3'b100 (dash pattern).
- Write handshake:
  - upd_ready is low only when state==BLANK && upd_idx==idx, so a digit is never torn while it is being loaded.
  - Otherwise upd_ready is high.
  - A write to upd_idx ≥ NUM_DIGITS completes the handshake and is discarded.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: digit_sel=0, blank=1, idx=0, timer=0, code_out holds. en=1 → BLANK.
  - BLANK: digit_sel=0, blank=1. After BLANK_CYCLES cycles → SHOW, and code_out ← table[idx] on that transition edge.
  - SHOW: digit_sel=1<<idx, blank=0. After HOLD_CYCLES cycles:
    - idx ← (idx==NUM_DIGITS-1) ? 0 : idx+1;
    - → BLANK;
    - scan_wrap=1 for that one cycle if idx was NUM_DIGITS-1.
  - en=0 in any state → IDLE on the next edge. Timer and idx clear; the table is kept.
- A write to the digit currently in SHOW updates the table only. code_out changes on that digit's next visit.
- The timer is a single down-counter, reloaded on each state entry. Width is $clog2(max(HOLD_CYCLES, BLANK_CYCLES)+1).

## Timing
- Reset (async assert, synchronous release of state):
  - state=IDLE, idx=0, code_out=3'b100, digit_sel=0, blank=1, scan_wrap=0;
  - all table entries 3'b100;
  - upd_ready=1.
- Enable and scan timing:
  - en sampled high at edge E0: BLANK during cycles E0+1..E0+BLANK_CYCLES.
  - The first SHOW cycle is E0+BLANK_CYCLES+1, with digit 0 lit.
  - Digit period is BLANK_CYCLES+HOLD_CYCLES; frame is NUM_DIGITS×(BLANK_CYCLES+HOLD_CYCLES).
- Write-to-display latency: a write accepted at edge W appears on code_out at the first BLANK→SHOW transition of that digit after W.
- A write accepted on the same edge as that digit's load transition is not possible, because ready is low then.
- Outputs are all registered, except upd_ready, which is combinational from state, idx and upd_idx.
- Mid-operation events:
  - rst_n low mid-SHOW: outputs go to their reset values immediately.
  - en low mid-SHOW: digit_sel=0 and blank=1 from the next edge.

## Structure
- Shared package test_disp_pkg holds:
  - state enum {IDLE, BLANK, SHOW};
  - localparam RESET_CODE = 3'b100;
  - code width constant CODE_W = 3.
- One sub-module, disp_timer: loadable down-counter with a done flag, parameterised width. The FSM, table and handshake live in the top.

## Test plan
- Reset, then en=1 with defaults: BLANK for 16 cycles; digit_sel=4'b0001 and code_out=3'b100 for 1000 cycles; digit order 0,1,2,3,0.
- scan_wrap pulse: exactly one cycle high, once per 4064 cycles. digit_sel is never non-zero while blank=1.
- Write idx=2 code=3'b001 during digit 0 SHOW: upd_ready=1, accepted. code_out=3'b001 on digit 2's SHOW, other digits stay 3'b100.
- Handshake stall: upd_valid with idx=1 during digit 1 BLANK gives upd_ready=0 until SHOW starts. Writing idx=1 during digit 1 SHOW leaves code_out unchanged until the next frame.
- Out-of-range write (NUM_DIGITS=3, idx=3): handshake completes and no table entry changes.
- Interruptions:
  - en low mid-SHOW of digit 2: blank=1 and digit_sel=0 on the next edge; on re-enable the scan restarts at digit 0 after BLANK_CYCLES.
  - rst_n pulse mid-scan: all outputs and the table return to their reset values.

Source files
------------

// File: rtl/test_disp_pkg.sv
// Shared types and constants for the test-status display scanner.
package test_disp_pkg;

    localparam int CODE_W = 3;
    localparam logic [CODE_W-1:0] RESET_CODE = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

endpackage

// File: rtl/disp_timer.sv
// Loadable down-counter; done is high while the count is zero. Load wins over decrement.
// Latency: load value visible next cycle; no backpressure.
module disp_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/test_disp_scanner.sv
// Scans a table of 3-bit status codes onto one shared decoder with blanking gaps.
// Outputs registered (upd_ready combinational); writes stall only for the digit being loaded.
module test_disp_scanner
    import test_disp_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int HOLD_CYCLES  = 1000,
    parameter  int BLANK_CYCLES = 16,
    localparam int IW           = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  upd_valid,
    input  logic [IW-1:0]         upd_idx,
    input  logic [CODE_W-1:0]     upd_code,
    output logic                  upd_ready,
    output logic [CODE_W-1:0]     code_out,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  blank,
    output logic                  scan_wrap
);

    localparam int MAXC = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    // Timer is loaded with N-1 so a state lasts exactly N cycles.
    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LD = TW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    state_t                  state, state_d;
    logic [IW-1:0]           idx, idx_d;
    logic [CODE_W-1:0]       code_d;
    logic [NUM_DIGITS-1:0]   sel_d;
    logic                    blank_d;
    logic                    wrap_d;
    logic                    tmr_load;
    logic [TW-1:0]           tmr_val;
    logic                    tmr_done;
    logic                    wr_en;
    logic [CODE_W-1:0]       tbl [NUM_DIGITS];

    disp_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Hold off a write only to the digit whose code is about to be latched.
    assign upd_ready = !((state == BLANK) && (upd_idx == idx));
    assign wr_en     = upd_valid && upd_ready && (int'(upd_idx) < NUM_DIGITS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                tbl[i] <= RESET_CODE;
            end
        end else if (wr_en) begin
            tbl[upd_idx] <= upd_code;
        end
    end

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        code_d   = code_out;
        wrap_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (!en) begin
            state_d  = IDLE;
            idx_d    = '0;
            tmr_load = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_d  = BLANK;
                    tmr_load = 1'b1;
                    tmr_val  = BLANK_LD;
                end
                BLANK: begin
                    if (tmr_done) begin
                        state_d  = SHOW;
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LD;
                        code_d   = tbl[idx];
                    end
                end
                SHOW: begin
                    if (tmr_done) begin
                        state_d  = BLANK;
                        tmr_load = 1'b1;
                        tmr_val  = BLANK_LD;
                        idx_d    = (idx == LAST_IDX) ? '0 : idx + 1'b1;
                        wrap_d   = (idx == LAST_IDX);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        sel_d   = (state_d == SHOW) ? (NUM_DIGITS'(1) << idx_d) : '0;
        blank_d = (state_d != SHOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            code_out  <= RESET_CODE;
            digit_sel <= '0;
            blank     <= 1'b1;
            scan_wrap <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            code_out  <= code_d;
            digit_sel <= sel_d;
            blank     <= blank_d;
            scan_wrap <= wrap_d;
        end
    end

endmodule

// File: tb/tb_test_disp_scanner.sv
// Scoreboard bench for test_disp_scanner: default-size scanner plus a small 3-digit one.
module tb_test_disp_scanner;
    import test_disp_pkg::*;

    localparam int ND  = 4;
    localparam int HC  = 1000;
    localparam int BC  = 16;
    localparam int P   = HC + BC;
    localparam int HC3 = 4;
    localparam int BC3 = 2;
    localparam int P3  = HC3 + BC3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       en = 1'b0, upd_valid = 1'b0;
    logic [1:0] upd_idx = '0;
    logic [2:0] upd_code = '0;
    logic       upd_ready, blank, scan_wrap;
    logic [2:0] code_out;
    logic [3:0] digit_sel;

    logic       en3 = 1'b0, upd_valid3 = 1'b0;
    logic [1:0] upd_idx3 = '0;
    logic [2:0] upd_code3 = '0;
    logic       upd_ready3, blank3, wrap3;
    logic [2:0] code3;
    logic [2:0] sel3;

    test_disp_scanner #(.NUM_DIGITS(ND), .HOLD_CYCLES(HC), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .upd_valid(upd_valid), .upd_idx(upd_idx),
        .upd_code(upd_code), .upd_ready(upd_ready), .code_out(code_out),
        .digit_sel(digit_sel), .blank(blank), .scan_wrap(scan_wrap)
    );

    test_disp_scanner #(.NUM_DIGITS(3), .HOLD_CYCLES(HC3), .BLANK_CYCLES(BC3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .upd_valid(upd_valid3), .upd_idx(upd_idx3),
        .upd_code(upd_code3), .upd_ready(upd_ready3), .code_out(code3),
        .digit_sel(sel3), .blank(blank3), .scan_wrap(wrap3)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    typedef struct {
        int at;
        int sel;
        int code;
    } visit_t;

    visit_t     show_q[$];
    int         wrap_q[$];
    logic [2:0] m_tbl [ND];

    task automatic push_visit(input int d, input int at);
        visit_t v;
        v.at   = at;
        v.sel  = 1 << d;
        v.code = int'(m_tbl[d]);
        show_q.push_back(v);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Holds a write request until accepted; returns the cycle in which ready was seen.
    task automatic wr(input int idx, input int code, output int rdy_cyc);
        int k;
        k = 0;
        upd_valid = 1'b1;
        upd_idx   = 2'(idx);
        upd_code  = 3'(code);
        #1;
        while (!upd_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        rdy_cyc = cyc;
        if (!upd_ready) chk("wr_timeout", int'(upd_ready), 1);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        @(negedge clk);
    endtask

    int   bad_ovl = 0, bad_code = 0;
    logic prev_blank = 1'b1;
    logic [2:0] prev_code = 3'b100;

    initial forever begin
        @(posedge clk);
        #1;
        if (blank && digit_sel != 4'b0) bad_ovl++;
        if (!blank && $countones(digit_sel) != 1) bad_ovl++;
        if (!blank && !prev_blank && code_out != prev_code) bad_code++;
        if (prev_blank && !blank) begin
            if (show_q.size() == 0) begin
                chk("show_unexp", int'(digit_sel), 0);
            end else begin
                visit_t v;
                v = show_q.pop_front();
                chk("show_cyc", cyc, v.at);
                chk("show_sel", int'(digit_sel), v.sel);
                chk("show_code", int'(code_out), v.code);
            end
        end
        if (scan_wrap) begin
            if (wrap_q.size() == 0) chk("wrap_unexp", int'(scan_wrap), 0);
            else chk("wrap_cyc", cyc, wrap_q.pop_front());
        end
        prev_blank = blank;
        prev_code  = code_out;
    end

    initial begin
        int c, s0, s, f2, f3, e0, rc;
        for (int i = 0; i < ND; i++) m_tbl[i] = 3'b100;

        repeat (3) @(negedge clk);
        chk("rst_code", int'(code_out), 4);
        chk("rst_sel", int'(digit_sel), 0);
        chk("rst_blank", int'(blank), 1);
        chk("rst_wrap", int'(scan_wrap), 0);
        chk("rst_ready", int'(upd_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Small scanner: out-of-range write is accepted and dropped, in-range write lands.
        upd_valid3 = 1'b1; upd_idx3 = 2'd3; upd_code3 = 3'b111;
        #1 chk("oor_ready", int'(upd_ready3), 1);
        @(negedge clk);
        upd_idx3 = 2'd1; upd_code3 = 3'b011;
        #1 chk("d3_wr_ready", int'(upd_ready3), 1);
        @(negedge clk);
        upd_valid3 = 1'b0;
        c = cyc; en3 = 1'b1; e0 = c + 1;
        for (int k = 0; k < 3; k++) begin
            wait_cyc(e0 + BC3 + k * P3);
            chk("d3_sel", int'(sel3), 1 << k);
            chk("d3_code", int'(code3), (k == 1) ? 3 : 4);
        end
        wait_cyc(e0 + BC3 + 2 * P3 + HC3);
        chk("d3_wrap", int'(wrap3), 1);
        @(negedge clk);
        chk("d3_wrap_width", int'(wrap3), 0);
        en3 = 1'b0;

        // Frame 1: write digit 2 during digit 0 SHOW, then stall on digit 1 during its BLANK.
        c = cyc; en = 1'b1; s0 = c + 1 + BC;
        push_visit(0, s0);
        wait_cyc(s0 + 10);
        chk("show0_blank", int'(blank), 0);
        wr(2, 1, rc);
        chk("wr2_rdy_cyc", rc, s0 + 10);
        m_tbl[2] = 3'b001;
        push_visit(1, s0 + P);
        push_visit(2, s0 + 2 * P);
        push_visit(3, s0 + 3 * P);
        wrap_q.push_back(s0 + 3 * P + HC);

        wait_cyc(s0 + HC + 2);
        upd_valid = 1'b1; upd_idx = 2'd1; upd_code = 3'b010;
        #1;
        chk("stall_ready", int'(upd_ready), 0);
        chk("stall_blank", int'(blank), 1);
        wr(1, 2, rc);
        chk("wr1_rdy_cyc", rc, s0 + P);
        m_tbl[1] = 3'b010;

        f2 = s0 + 4 * P;
        for (int d = 0; d < ND; d++) push_visit(d, f2 + d * P);
        wrap_q.push_back(f2 + 3 * P + HC);

        // Frame 3 is cut short by dropping en during digit 2.
        f3 = s0 + 8 * P;
        for (int d = 0; d < 3; d++) push_visit(d, f3 + d * P);
        wait_cyc(f3 + 2 * P + 100);
        chk("pre_dis_sel", int'(digit_sel), 4);
        en = 1'b0;
        @(negedge clk);
        chk("dis_blank", int'(blank), 1);
        chk("dis_sel", int'(digit_sel), 0);
        chk("dis_wrap", int'(scan_wrap), 0);
        repeat (50) @(negedge clk);
        chk("idle_code_hold", int'(code_out), 1);
        chk("idle_blank", int'(blank), 1);

        c = cyc; en = 1'b1; s = c + 1 + BC;
        push_visit(0, s);
        wait_cyc(s + 20);
        chk("pre_rst_sel", int'(digit_sel), 1);

        // Asynchronous reset mid-SHOW; table must come back to the dash code.
        rst_n = 1'b0; en = 1'b0;
        #1;
        chk("arst_code", int'(code_out), 4);
        chk("arst_sel", int'(digit_sel), 0);
        chk("arst_blank", int'(blank), 1);
        chk("arst_wrap", int'(scan_wrap), 0);
        chk("arst_ready", int'(upd_ready), 1);
        for (int i = 0; i < ND; i++) m_tbl[i] = 3'b100;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        c = cyc; en = 1'b1; s = c + 1 + BC;
        for (int d = 0; d < ND; d++) push_visit(d, s + d * P);
        wrap_q.push_back(s + 3 * P + HC);
        wait_cyc(s + 3 * P + HC + 5);

        chk("show_q_left", show_q.size(), 0);
        chk("wrap_q_left", wrap_q.size(), 0);
        chk("sel_while_blank", bad_ovl, 0);
        chk("code_change_in_show", bad_code, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
